// File: rtl/fib_seq_gen.sv
// Fibonacci stream source: programmable seeds, term count and wrap/saturate
// arithmetic, with a valid/ready output and a one-cycle done pulse per run.
module fib_seq_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] seed0_i,
    input  logic [WIDTH-1:0] seed1_i,
    input  logic [CNT_W-1:0] n_terms_i,
    input  logic             mode_sat_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [0:0]       state_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] next_b;
    logic             hs;

    // Stream handshake: a term transfers in any cycle where out_valid_o and
    // out_ready_i are both high; while valid is high and ready is low every
    // register holds, so out_data_o cannot change until it is accepted.
    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        carry  = sum[WIDTH];
        next_b = (carry && sat_q) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        hs     = (state_q == S_RUN) && out_ready_i;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d   = seed0_i;
                    b_d   = seed1_i;
                    cnt_d = n_terms_i;
                    sat_d = mode_sat_i;
                    ovf_d = 1'b0;
                    // A zero-length run completes immediately without emitting.
                    if (n_terms_i != '0) begin
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (hs) begin
                    a_d   = b_q;
                    b_d   = next_b;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (carry) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign out_data_o  = a_q;
    assign out_valid_o = (state_q == S_RUN);
    assign busy_o      = (state_q == S_RUN);
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;
    assign state_o     = state_q;

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised Fibonacci sequence generator with programmable seeds, term count, wrap/saturate arithmetic and a valid/ready output stream. It supersedes the free-running 8-bit Fibonacci counter. It sits as a stream source feeding downstream consumers (FIFOs, UART/display formatters) that may apply backpressure. Each run is launched by a one-cycle `start` and ends with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 16: data width of seeds and terms (≥2).
- `CNT_W`, default 8: width of the term counter; max run length is 2^CNT_W−1 terms.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  launch a run; sampled only in IDLE.
- `seed0`  in  WIDTH  first term F0; sampled on accepted `start`.
- `seed1`  in  WIDTH  second term F1; sampled on accepted `start`.
- `n_terms`  in  CNT_W  number of terms to emit; sampled on accepted `start`.
- `mode_sat`  in  1  0 = wrap modulo 2^WIDTH, 1 = saturate at all-ones; sampled on accepted `start`.
- `out_data`  out  WIDTH  current term.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the term.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at the end of a run.
- `overflow`  out  1  sticky: the run produced a carry out of WIDTH bits.

## Operation
- Registers: `a` (current term), `b` (next term), `cnt` (terms remaining), `sat_r` (latched mode), FSM state.
- States:
  - IDLE: `out_valid`=0, `busy`=0.
  - RUN: `out_valid`=1, `busy`=1, `out_data`=`a`.
- IDLE with `start`=1:
  - Load `a`=`seed0`, `b`=`seed1`, `cnt`=`n_terms`, `sat_r`=`mode_sat`, and clear `overflow`.
  - If `n_terms`≠0, go to RUN.
  - If `n_terms`=0, stay in IDLE and pulse `done` in the next cycle. No term is emitted.
- RUN, handshake (`out_valid`&`out_ready`):
  - `a`←`b`.
  - `b`←next, where sum = `a`+`b` computed at WIDTH+1 bits. next = sum[WIDTH−1:0] if `sat_r`=0; next = all-ones if carry and `sat_r`=1.
  - If carry, set `overflow` (sticky until the next accepted `start` or `rst`).
  - `cnt`←`cnt`−1. If `cnt`=1, go to IDLE and pulse `done`.
- RUN without handshake: all registers hold, so `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- `start` while in RUN is ignored. Seeds and mode changes mid-run have no effect.
- Overflow is evaluated on every handshake, including the final one, even though the term it computes is never emitted.
- `out_data` outside RUN equals `a`; consumers must qualify it with `out_valid`.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `overflow`=0, state IDLE, `a`=`b`=`cnt`=0.
- `rst` mid-run aborts immediately (asynchronous). No `done` pulse follows; the next run needs a new `start`.
- `start` sampled high in cycle k → `out_valid`=1 and `out_data`=`seed0` in cycle k+1.
- Throughput with `out_ready` held high: one term per cycle, with no bubbles.
- Final handshake in cycle m → `done`=1, `out_valid`=0 and `busy`=0 in cycle m+1. `done` is high for exactly one cycle.
- `start` accepted in the same cycle `done` is high (FSM already in IDLE) is legal. In that case the next run's first term appears in the following cycle.
- `n_terms`=0 with `start` in cycle k → `done` in cycle k+1 only.
- `overflow` rises in the cycle after the handshake that carried out.

## Test plan
- WIDTH=8, seeds 0/1, `n_terms`=14, wrap, `out_ready`=1:
  - Output 0,1,1,2,3,5,8,13,21,34,55,89,144,233 on consecutive cycles.
  - `overflow` rises after the handshake of 144 (sum 377).
  - `done` appears one cycle after 233.
- WIDTH=8, seeds 0/1, `n_terms`=16:
  - Wrap: the last four terms are 144,233,121,98.
  - `mode_sat`=1: the last four terms are 144,233,255,255, and `overflow`=1.
- Backpressure: seeds 3/4, `n_terms`=6, `out_ready` toggled randomly → sequence 3,4,7,11,18,29. `out_data` is stable while stalled, and there are no duplicates or drops.
- `n_terms`=0 → `done` pulses once one cycle after `start`. `out_valid` never rises.
- Reset and restart:
  - Assert `rst` during the 3rd term of a run → all outputs return to reset values at once, with no `done`.
  - `start` during RUN is ignored; the run completes with the original seeds.
- Back-to-back: `start` asserted in the `done` cycle with new seeds 5/5, `n_terms`=3 → output 5,5,10. `overflow` from the prior run is cleared.
